// File: rtl/i2c_target_regs.sv
// I2C target exposing NUM_REGS bytes of register image to an external controller.
// Supports pointer writes, register writes and burst reads from a coherent snapshot.
`timescale 1ns/1ps
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         NUM_REGS = 8,
    parameter int         PTR_W    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SCL,
    inout  wire                   SDA,
    input  logic [8*NUM_REGS-1:0] rd_data,
    output logic                  wr_strobe,
    output logic [PTR_W-1:0]      wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    logic scl_s1_q, scl_s2_q, scl_prev_q;
    logic sda_s1_q, sda_s2_q, sda_prev_q;
    logic sda_in;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [6:0]        shift_q, shift_d;
    logic              rw_q, rw_d;
    logic              ack_on_q, ack_on_d;
    logic              first_q, first_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic [PTR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [8*NUM_REGS-1:0] shadow_q;
    logic              shadow_load;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in, cur_byte, live_byte;
    logic [2:0] bit_idx;

    assign sda_in = SDA;
    assign SDA    = sda_oe_q ? 1'b0 : 1'bz;

    assign scl_rise  = scl_s2_q & ~scl_prev_q;
    assign scl_fall  = ~scl_s2_q & scl_prev_q;
    assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;

    assign byte_in   = {shift_q, sda_s2_q};
    assign cur_byte  = shadow_q[{ptr_q, 3'b000} +: 8];
    assign live_byte = rd_data[{ptr_q, 3'b000} +: 8];
    assign bit_idx   = 3'(4'd7 - cnt_q);

    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;

    // Synchronisers idle high so reset release never looks like a START.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_s1_q   <= SCL;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= sda_in;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            ack_on_q    <= 1'b0;
            first_q     <= 1'b0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            ack_on_q    <= ack_on_d;
            first_q     <= first_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (shadow_load) shadow_q <= rd_data;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        ack_on_d    = ack_on_q;
        first_d     = first_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        shadow_load = 1'b0;

        if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            ack_on_d = 1'b0;
        end else if (start_det) begin
            state_d  = ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            ack_on_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d = byte_in[6:0];
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = '0;
                        rw_d  = sda_s2_q;
                        if (shift_q == DEV_ADDR) begin
                            state_d = ADDR_ACK;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                // First fall starts the ACK low, second fall ends the ACK period.
                ADDR_ACK: if (scl_fall) begin
                    if (!ack_on_q) begin
                        ack_on_d = 1'b1;
                        sda_oe_d = 1'b1;
                    end else begin
                        ack_on_d = 1'b0;
                        cnt_d    = '0;
                        if (rw_q) begin
                            shadow_load = 1'b1;
                            state_d     = RD_BYTE;
                            sda_oe_d    = ~live_byte[7];
                        end else begin
                            state_d  = WR_BYTE;
                            first_d  = 1'b1;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                WR_BYTE: if (scl_rise) begin
                    shift_d = byte_in[6:0];
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = '0;
                        state_d = WR_ACK;
                        if (first_q) begin
                            ptr_d   = byte_in[PTR_W-1:0];
                            first_d = 1'b0;
                        end else begin
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = ptr_q;
                            wr_data_d   = byte_in;
                            ptr_d       = ptr_q + PTR_W'(1);
                        end
                    end
                end
                WR_ACK: if (scl_fall) begin
                    if (!ack_on_q) begin
                        ack_on_d = 1'b1;
                        sda_oe_d = 1'b1;
                    end else begin
                        ack_on_d = 1'b0;
                        sda_oe_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = WR_BYTE;
                    end
                end
                RD_BYTE: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = RD_ACK;
                        end else begin
                            sda_oe_d = ~cur_byte[bit_idx];
                        end
                    end
                end
                // cnt_q==1 marks an ACK seen, so the next fall presents the next byte.
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s2_q) begin
                            state_d = IGNORE;
                        end else begin
                            ptr_d = ptr_q + PTR_W'(1);
                            cnt_d = 4'd1;
                        end
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        state_d  = RD_BYTE;
                        cnt_d    = '0;
                        sda_oe_d = ~cur_byte[7];
                    end
                end
                IDLE, IGNORE: ;
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged controller plus a transaction-level model
// of the register pointer, expected writes and read snapshot.
`timescale 1ns/1ps
module tb_i2c_target_regs;

    localparam int Q = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_scl = 1'b1;
    logic        m_sda_low = 1'b0;
    logic [63:0] rd_data = '0;
    wire         SDA;
    logic        wr_strobe;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    assign SDA = m_sda_low ? 1'b0 : 1'bz;
    pullup (SDA);

    always #5 clk = ~clk;

    i2c_target_regs #(.DEV_ADDR(7'h42), .NUM_REGS(8), .PTR_W(3)) dut (
        .clk(clk), .reset(rst_n), .SCL(m_scl), .SDA(SDA), .rd_data(rd_data),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    typedef struct { logic [2:0] a; logic [7:0] d; } wr_t;

    int         tests = 0;
    int         fails = 0;
    logic [2:0] ptr_m;
    logic [7:0] snap_m [8];
    wr_t        exp_q [$];
    wr_t        e;
    bit         no_drive = 1'b0;
    bit         drove = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every strobe must match the next write the model predicts.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_strobe) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_strobe: got addr %0h data %0h expected none", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({wr_addr, wr_data} !== {e.a, e.d}) begin
                        fails++;
                        $display("FAIL strobe: got addr %0h data %0h expected addr %0h data %0h",
                                 wr_addr, wr_data, e.a, e.d);
                    end
                end
            end
            if (no_drive && !m_sda_low && SDA !== 1'b1) drove = 1'b1;
        end
    end

    task automatic m_start();
        m_sda_low = 1'b0; #Q;
        m_scl = 1'b1;     #Q;
        m_sda_low = 1'b1; #Q;
        m_scl = 1'b0;     #Q;
    endtask

    task automatic m_stop();
        m_sda_low = 1'b1; #Q;
        m_scl = 1'b1;     #Q;
        m_sda_low = 1'b0; #Q;
    endtask

    task automatic m_bit(input logic b, output logic s);
        m_sda_low = ~b; #Q;
        m_scl = 1'b1;   #Q;
        s = SDA;        #Q;
        m_scl = 1'b0;   #Q;
    endtask

    task automatic m_wbyte(input logic [7:0] v, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) m_bit(v[i], s);
        m_bit(1'b1, s);
        ack = s;
    endtask

    task automatic m_rbyte(input logic nack, output logic [7:0] v);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, s);
            v[i] = s;
        end
        m_bit(nack, s);
    endtask

    task automatic send_ack(input string name, input logic [7:0] v);
        logic a;
        m_wbyte(v, a);
        check(name, a, 1'b0);
    endtask

    // Data byte of a write: first loads the pointer, the rest become register writes.
    task automatic send_data(input string name, input logic [7:0] v, input bit first);
        if (first) ptr_m = v[2:0];
        else begin
            exp_q.push_back('{a: ptr_m, d: v});
            ptr_m = ptr_m + 3'd1;
        end
        send_ack(name, v);
    endtask

    task automatic snap();
        for (int i = 0; i < 8; i++) snap_m[i] = rd_data[8*i +: 8];
    endtask

    task automatic read_chk(input string name, input logic nack, output logic [7:0] v);
        m_rbyte(nack, v);
        check(name, v, snap_m[ptr_m]);
        if (!nack) ptr_m = ptr_m + 3'd1;
    endtask

    initial begin
        logic [7:0] v;
        logic       a;
        logic [7:0] lit2 [4];
        lit2 = '{8'h06, 8'h07, 8'h08, 8'h01};
        ptr_m = '0;

        #(3*Q);
        check("rst_strobe", wr_strobe, 1'b0);
        check("rst_addr", wr_addr, 3'd0);
        check("rst_data", wr_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_sda", SDA, 1'b1);
        rst_n = 1'b1; #Q;

        // Pointer write then one register write
        m_start();
        send_ack("t1_addr", 8'h84);
        check("t1_busy_on", busy, 1'b1);
        send_data("t1_ptr", 8'h02, 1'b1);
        send_data("t1_data", 8'hA5, 1'b0);
        m_stop();
        check("t1_busy_off", busy, 1'b0);
        check("t1_wr_addr", wr_addr, 3'd2);
        check("t1_wr_data", wr_data, 8'hA5);
        check("t1_ptr_model", ptr_m, 3'd3);

        // Direct read uses the pointer left at 3
        rd_data = 64'h1122334455667788;
        snap();
        m_start();
        send_ack("t1b_addr", 8'h85);
        read_chk("t1b_rd", 1'b1, v);
        check("t1b_lit", v, 8'h55);
        m_stop();

        // Pointer write, repeated START, wrapping 4-byte read
        rd_data = 64'h0807060504030201;
        m_start();
        send_ack("t2_addr_w", 8'h84);
        send_data("t2_ptr", 8'h05, 1'b1);
        m_start();
        send_ack("t2_addr_r", 8'h85);
        snap();
        for (int i = 0; i < 4; i++) begin
            read_chk("t2_rd", (i == 3), v);
            check("t2_lit", v, lit2[i]);
        end
        m_stop();

        // Address mismatch: no ACK, no drive, not busy
        no_drive = 1'b1;
        drove = 1'b0;
        m_start();
        m_wbyte(8'h90, a);
        check("t3_nack", a, 1'b1);
        check("t3_busy", busy, 1'b0);
        m_wbyte(8'h12, a);
        check("t3_nack2", a, 1'b1);
        m_stop();
        no_drive = 1'b0;
        check("t3_no_drive", drove, 1'b0);
        check("t3_busy_end", busy, 1'b0);

        // Snapshot coherence across a rd_data change mid-burst
        rd_data = 64'hF0E1D2C3B4A59687;
        m_start();
        send_ack("t4_addr_w", 8'h84);
        send_data("t4_ptr", 8'h02, 1'b1);
        m_start();
        send_ack("t4_addr_r", 8'h85);
        snap();
        read_chk("t4_rd0", 1'b0, v);
        check("t4_lit0", v, 8'hA5);
        rd_data = ~rd_data;
        read_chk("t4_rd1", 1'b1, v);
        check("t4_lit1", v, 8'hB4);
        m_stop();

        // STOP mid-byte discards it; then writes that wrap the pointer
        m_start();
        send_ack("t5_addr", 8'h84);
        send_data("t5_ptr", 8'h03, 1'b1);
        for (int i = 0; i < 4; i++) m_bit(1'b1, a);
        m_stop();
        check("t5_sda", SDA, 1'b1);
        check("t5_busy", busy, 1'b0);
        m_start();
        send_ack("t5_addr2", 8'h84);
        send_data("t5_ptr2", 8'h06, 1'b1);
        send_data("t5_d0", 8'h77, 1'b0);
        send_data("t5_d1", 8'h88, 1'b0);
        send_data("t5_d2", 8'h99, 1'b0);
        m_stop();
        check("t5_wr_addr", wr_addr, 3'd0);
        check("t5_wr_data", wr_data, 8'h99);
        check("t5_pending", exp_q.size(), 0);

        // Reset while the target drives a 0 read bit
        rd_data = 64'h776600443322115A;
        m_start();
        send_ack("t6_addr_w", 8'h84);
        send_data("t6_ptr", 8'h05, 1'b1);
        m_start();
        send_ack("t6_addr_r", 8'h85);
        check("t6_drive0", SDA, 1'b0);
        rst_n = 1'b0; #1;
        check("t6_sda_async", SDA, 1'b1);
        check("t6_strobe", wr_strobe, 1'b0);
        check("t6_addr", wr_addr, 3'd0);
        check("t6_data", wr_data, 8'h00);
        check("t6_busy", busy, 1'b0);
        ptr_m = '0;
        m_sda_low = 1'b0;
        m_scl = 1'b1;
        #Q;
        rst_n = 1'b1; #Q;
        snap();
        m_start();
        send_ack("t6_addr_r2", 8'h85);
        read_chk("t6_rd", 1'b1, v);
        check("t6_lit", v, 8'h5A);
        m_stop();

        #Q;
        check("final_pending", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
